// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the single-clock FIFO family.
package fifo_pkg;

    // Read-port behaviour of the FIFO.
    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } read_mode_e;

    // Pointer width: enough bits to address every entry.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: one extra bit so the value FIFO_DEPTH fits.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               i_we,
    input  logic [ptr_width(FIFO_DEPTH)-1:0]   i_waddr,
    input  logic [FIFO_WIDTH-1:0]              i_wdata,
    input  logic [ptr_width(FIFO_DEPTH)-1:0]   i_raddr,
    output logic [FIFO_WIDTH-1:0]              o_rdata
);

    // Not reset: contents are only meaningful between the pointers.
    logic [FIFO_WIDTH-1:0] memory [FIFO_DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            memory[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = memory[i_raddr];

endmodule

// File: rtl/sync_fifo_pf.sv
// Single-clock FIFO with threshold flags, occupancy count, write ack, overflow/underflow
// pulses and a selectable standard or first-word-fall-through read port.
module sync_fifo_pf
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wen,
    input  logic                             ren,
    input  logic [FIFO_WIDTH-1:0]            din,
    output logic [FIFO_WIDTH-1:0]            dout,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic [cnt_width(FIFO_DEPTH)-1:0] count,
    output logic                             wr_ack,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int unsigned PtrW = ptr_width(FIFO_DEPTH);
    localparam int unsigned CntW = cnt_width(FIFO_DEPTH);
    localparam read_mode_e  Mode = (FWFT != 0) ? MODE_FWFT : MODE_STD;

    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] AfCnt   = CntW'(AF_THRESH);
    localparam logic [CntW-1:0] AeCnt   = CntW'(AE_THRESH);

    // Parameter range checks.
    if (FIFO_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_pf: FIFO_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_pf: FIFO_DEPTH must be a power of two >= 4");
    end
    if (FWFT > 1) begin : g_bad_fwft
        $error("sync_fifo_pf: FWFT must be 0 or 1");
    end
    if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
        $error("sync_fifo_pf: AF_THRESH must be in 1..FIFO_DEPTH");
    end
    if (AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_pf: AE_THRESH must be in 0..FIFO_DEPTH-1");
    end

    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [CntW-1:0]       r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [FIFO_WIDTH-1:0] w_rd_data;

    // Flags decode only from the registered count, so acceptance never depends on same-cycle
    // requests: a full FIFO refuses a write even when a read frees a slot this cycle.
    assign w_full   = (r_count == FullCnt);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wen && !w_full;
    assign w_rd_acc = ren && !w_empty;

    fifo_ram #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    // Pointers, occupancy and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wen && w_full;
            r_underflow <= ren && w_empty;
        end
    end

    if (Mode == MODE_STD) begin : g_std
        logic [FIFO_WIDTH-1:0] r_dout;

        // Registered read: dout updates only on an accepted read.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_dout <= '0;
            end else if (w_rd_acc) begin
                r_dout <= w_rd_data;
            end
        end

        assign dout = r_dout;
    end else begin : g_fwft
        // Head word is presented directly; zero while nothing is stored.
        assign dout = w_empty ? '0 : w_rd_data;
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AfCnt);
    assign almost_empty = (r_count <= AeCnt);
    assign count        = r_count;
    assign wr_ack       = r_wr_ack;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: doc/sync_fifo_pf.md
# sync_fifo_pf

Single-clock parametrised FIFO with programmable almost-full/almost-empty thresholds, occupancy count, write acknowledge, overflow/underflow reporting and a selectable first-word-fall-through (FWFT) read mode. It is the same-clock-domain successor to the team's dual-clock FIFO. It buffers data between producer and consumer stages sharing one clock where flow control needs early-warning flags rather than bare full/empty.

## Interface
- FIFO_WIDTH, 4: data width in bits, >=1.
- FIFO_DEPTH, 16: number of entries; power of two, >=4.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AF_THRESH, FIFO_DEPTH-2: almost_full asserts when count >= AF_THRESH; range 1..FIFO_DEPTH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH; range 0..FIFO_DEPTH-1.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wen  in  1  write request.
- ren  in  1  read request.
- din  in  FIFO_WIDTH  write data.
- dout  out  FIFO_WIDTH  read data.
- full, empty  out  1 each  occupancy flags.
- almost_full, almost_empty  out  1 each  threshold flags.
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- wr_ack  out  1  write accepted on previous edge.
- overflow  out  1  write rejected on previous edge.
- underflow  out  1  read rejected on previous edge.

## Operation
- Write accepted iff wen && !full; read accepted iff ren && !empty. Decided from registered flags only. A full FIFO rejects writes even when ren=1 the same cycle.
- Accepted write: mem[wr_ptr] <= din, wr_ptr += 1. Accepted read: rd_ptr += 1.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- full = (count == FIFO_DEPTH); empty = (count == 0); almost_full = (count >= AF_THRESH); almost_empty = (count <= AE_THRESH).
- All flags are registered, or decoded purely from registered count.
- wr_ack = 1 for one cycle after an accepted write. overflow = 1 for one cycle after wen && full. underflow = 1 for one cycle after ren && empty.
- Standard mode (FWFT=0): on an accepted read, dout <= mem[rd_ptr]. Otherwise dout holds its value.
- FWFT mode: dout = mem[rd_ptr] while !empty, and 0 while empty. An accepted read advances to the next word.
- Reset while rst_n=0 at a rising edge:
  - pointers, count, dout, wr_ack, overflow and underflow return to 0;
  - empty=1, almost_empty=1, full=0, almost_full=0;
  - memory contents are not cleared;
  - the reset edge overrides any concurrent wen/ren.

## Timing
- Write-to-flag latency is 1 cycle. empty deasserts on the edge that accepts the first write.
- Standard mode read latency is 1 cycle: data on dout after the edge that accepted ren.
- FWFT: a word written into an empty FIFO is visible on dout immediately after the write edge, together with empty=0.
- Simultaneous read and write at count=0: the write is accepted and the read is rejected (underflow=1). Result: count=1.
- Simultaneous read and write at count=FIFO_DEPTH: the read is accepted and the write is rejected (overflow=1). Result: count=FIFO_DEPTH-1.
- Maximum sustained throughput is one write and one read per cycle, with no bubbles at pointer wrap.

## Structure
- Shared package fifo_pkg:
  - function/constant for pointer width ($clog2(FIFO_DEPTH)) and count width;
  - read-mode enum (MODE_STD, MODE_FWFT).
- Sub-module fifo_ram: simple dual-port register array, one write port and one asynchronous read port, parametrised by FIFO_WIDTH and FIFO_DEPTH. Its array is named memory so benches can preload it hierarchically.
- Top level holds pointers, count, flag logic and output registers.
- Elaboration-time assertions check the parameter ranges above.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with wen=ren=1 -> count=0, empty=1, almost_empty=1, full=0, dout=0, all pulses 0.
- Fill (defaults, FWFT=0): write 1..15 then 0 on consecutive cycles.
  - almost_full asserts after the 14th write; full after the 16th; wr_ack=1 for all 16.
  - Three further writes -> overflow=1 each, count stays 16.
- Drain: ren=1 for 16 cycles -> dout sequence 1..15,0, each one cycle after its read; almost_empty at count=2; empty after the 16th read.
  - Three extra reads -> underflow=1 each, dout holds 0.
- Boundary simultaneity:
  - at count=16, wen=ren=1 -> count=15, overflow=1;
  - at count=0, wen=ren=1 -> count=1, underflow=1, wr_ack=1.
- Wrap: 1000 cycles of random wen/ren and random din against a queue model -> every read matches, count never exceeds 16, no data loss across pointer wrap.
- FWFT=1: write 0xA into an empty FIFO -> dout=0xA with empty=0 the next cycle, before any ren. Read it -> dout=0, empty=1.
